// File: rtl/bus_master_lsu_pkg.sv
// Shared encodings for the load/store bus initiator and its helpers.
package bus_master_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_SIZE     = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Store data is right-justified; bits above the transfer size go out as zero.
  function automatic logic [31:0] mask_wdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] m;
    case (size)
      SZ_BYTE: m = {24'd0, wdata[7:0]};
      SZ_HALF: m = {16'd0, wdata[15:0]};
      default: m = wdata;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bus_load_extend.sv
// Masks right-justified bus read data to the transfer size and sign/zero-extends it.
module bus_load_extend
  import bus_master_lsu_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  always_comb begin
    case (size_i)
      SZ_BYTE: data_o = {{24{signed_i & data_i[7]}}, data_i[7:0]};
      SZ_HALF: data_o = {{16{signed_i & data_i[15]}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/bus_master_lsu.sv
// CPU load/store to single system-bus transfer, with alignment check and ack timeout.
//   state   | meaning
//   IDLE    | waiting for req_i; reports size/alignment errors without a bus cycle
//   BUS     | strobe asserted, waiting for ack_i or timeout
//   RESP    | one-cycle done_o pulse
module bus_master_lsu
  import bus_master_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_req_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] addr_req_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  output logic [1:0]  sel_o,
  output logic        rd_o,
  output logic        we_o,
  input  logic [31:0] data_i,
  input  logic        ack_i
);

  localparam logic [TO_W-1:0] TC = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d, data_q, data_d, rdata_q, rdata_d;
  logic [1:0]      sel_q, sel_d, code_q, code_d;
  logic            rd_q, rd_d, we_q, we_d, sgn_q, sgn_d;
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [31:0]     ext_data;
  logic            req_bad_size, req_misalign;

  assign req_bad_size = (size_i == SZ_BAD);
  assign req_misalign = ((size_i == SZ_HALF) && addr_req_i[0]) ||
                        ((size_i == SZ_WORD) && (addr_req_i[1:0] != 2'b00));

  bus_load_extend u_ext (
    .data_i   (data_i),
    .size_i   (sel_q),
    .signed_i (sgn_q),
    .data_o   (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      sel_q   <= '0;
      code_q  <= '0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      sel_q   <= sel_d;
      code_q  <= code_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      sgn_q   <= sgn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_i && !req_bad_size && !req_misalign) state_d = ST_BUS;
      ST_BUS: begin
        // ack on the terminal-count edge still completes the transfer
        if (ack_i)            state_d = ST_RESP;
        else if (cnt_q == TC) state_d = ST_IDLE;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    sel_d   = sel_q;
    code_d  = code_q;
    rd_d    = rd_q;
    we_d    = we_q;
    sgn_d   = sgn_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          if (req_bad_size) begin
            err_d  = 1'b1;
            code_d = ERR_SIZE;
          end else if (req_misalign) begin
            err_d  = 1'b1;
            code_d = ERR_MISALIGN;
          end else begin
            addr_d = addr_req_i;
            sel_d  = size_i;
            data_d = mask_wdata(size_i, wdata_i);
            rd_d   = ~we_req_i;
            we_d   = we_req_i;
            sgn_d  = signed_i;
            cnt_d  = '0;
          end
        end
      end
      ST_BUS: begin
        if (ack_i) begin
          if (rd_q) rdata_d = ext_data;
          rd_d   = 1'b0;
          we_d   = 1'b0;
          done_d = 1'b1;
        end else if (cnt_q == TC) begin
          rd_d   = 1'b0;
          we_d   = 1'b0;
          err_d  = 1'b1;
          code_d = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign rdata_o    = rdata_q;
  assign err_o      = err_q;
  assign err_code_o = code_q;
  assign addr_o     = addr_q;
  assign data_o     = data_q;
  assign sel_o      = sel_q;
  assign rd_o       = rd_q;
  assign we_o       = we_q;

endmodule

// File: tb/tb_bus_master_lsu.sv
// Scoreboard bench for bus_master_lsu: expected responses queued at request time, popped on done_o/err_o.
module tb_bus_master_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, we_req_i, signed_i, ack_i;
  logic [1:0]  size_i;
  logic [31:0] addr_req_i, wdata_i, data_i;
  logic        busy_o, done_o, err_o, rd_o, we_o;
  logic [31:0] rdata_o, addr_o, data_o;
  logic [1:0]  err_code_o, sel_o;

  bus_master_lsu #(.TIMEOUT(8), .TO_W(16)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_req_i(we_req_i), .size_i(size_i),
    .signed_i(signed_i), .addr_req_i(addr_req_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .err_code_o(err_code_o), .addr_o(addr_o), .data_o(data_o), .sel_o(sel_o),
    .rd_o(rd_o), .we_o(we_o), .data_i(data_i), .ack_i(ack_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic is_err; logic [1:0] code; logic [31:0] rdata; } exp_t;
  typedef struct { logic [1:0] sz; logic sgn; logic [31:0] addr; logic [31:0] din; logic [31:0] exp; } ld_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_load = 32'h0;

  logic        obs_got, obs_is_err, obs_busy, obs_busy_end, obs_unstable;
  logic        obs_both_strobe = 1'b0, obs_both_resp = 1'b0;
  int          obs_rd, obs_we, obs_cycle;
  logic [1:0]  obs_code, obs_sel;
  logic [31:0] obs_rdata, obs_addr, obs_data;

  // delay: 0 = ack tied high, N>0 = ack on strobe cycle N+1, -1 = never ack
  task automatic run_xfer(input logic we, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd, input int delay);
    int s_cnt;
    @(negedge clk);
    req_i = 1'b1; we_req_i = we; size_i = sz; signed_i = sgn; addr_req_i = addr; wdata_i = wd;
    ack_i = (delay == 0);
    s_cnt = 0;
    obs_got = 0; obs_is_err = 0; obs_busy = 0; obs_busy_end = 0; obs_unstable = 0;
    obs_rd = 0; obs_we = 0; obs_cycle = 0; obs_code = 0; obs_sel = 0;
    obs_rdata = 0; obs_addr = 0; obs_data = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      req_i = 1'b0;
      if (rd_o) obs_rd++;
      if (we_o) obs_we++;
      if (rd_o && we_o) obs_both_strobe = 1'b1;
      if (busy_o) obs_busy = 1'b1;
      if (done_o && err_o) obs_both_resp = 1'b1;
      if (rd_o || we_o) begin
        s_cnt++;
        if (s_cnt == 1) begin
          obs_addr = addr_o; obs_data = data_o; obs_sel = sel_o;
        end else if (addr_o !== obs_addr || data_o !== obs_data || sel_o !== obs_sel) begin
          obs_unstable = 1'b1;
        end
      end
      if (done_o || err_o) begin
        obs_got = 1'b1; obs_is_err = err_o; obs_cycle = c; obs_code = err_code_o;
        obs_rdata = rdata_o; obs_busy_end = busy_o;
        break;
      end
      ack_i = (delay == 0) ? 1'b1 : ((delay > 0) && (s_cnt > delay));
    end
    ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_i = 0; we_req_i = 0; size_i = 0; signed_i = 0;
    addr_req_i = 0; wdata_i = 0; data_i = 0; ack_i = 0;
    repeat (3) @(negedge clk);
    n_checks++; if ({rd_o, we_o, busy_o, done_o, err_o} !== 5'b0) begin n_fail++; $display("FAIL reset_strobes got %b want 00000", {rd_o, we_o, busy_o, done_o, err_o}); end
    n_checks++; if (addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", addr_o); end
    n_checks++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", data_o); end
    n_checks++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata_o); end
    n_checks++; if ({sel_o, err_code_o} !== 4'h0) begin n_fail++; $display("FAIL reset_sel_code got %h want 0", {sel_o, err_code_o}); end
    rst = 1'b0;
  endtask

  task automatic test_load();
    ld_t  tbl[5];
    exp_t e;
    tbl[0] = '{2'd0, 1'b1, 32'h103, 32'h000000F0, 32'hFFFFFFF0};
    tbl[1] = '{2'd0, 1'b0, 32'h103, 32'h000000F0, 32'h000000F0};
    tbl[2] = '{2'd1, 1'b1, 32'h102, 32'h12348001, 32'hFFFF8001};
    tbl[3] = '{2'd1, 1'b0, 32'h102, 32'h12348001, 32'h00008001};
    tbl[4] = '{2'd2, 1'b1, 32'h108, 32'h89ABCDEF, 32'h89ABCDEF};
    for (int i = 0; i < 5; i++) begin
      data_i = tbl[i].din;
      sb.push_back('{1'b0, 2'd0, tbl[i].exp});
      run_xfer(1'b0, tbl[i].sz, tbl[i].sgn, tbl[i].addr, 32'hFFFFFFFF, 0);
      e = sb.pop_front();
      n_checks++; if (!obs_got || obs_is_err !== e.is_err) begin n_fail++; $display("FAIL load%0d_resp got=%0b err=%0b want done", i, obs_got, obs_is_err); end
      n_checks++; if (obs_rdata !== e.rdata) begin n_fail++; $display("FAIL load%0d_rdata got %h want %h", i, obs_rdata, e.rdata); end
      n_checks++; if (obs_cycle !== 2 || obs_rd !== 1 || obs_we !== 0) begin n_fail++; $display("FAIL load%0d_timing done_cyc %0d rd %0d we %0d want 2 1 0", i, obs_cycle, obs_rd, obs_we); end
      n_checks++; if (obs_sel !== tbl[i].sz || obs_addr !== tbl[i].addr) begin n_fail++; $display("FAIL load%0d_bus sel %0d addr %h want %0d %h", i, obs_sel, obs_addr, tbl[i].sz, tbl[i].addr); end
      last_load = e.rdata;
    end
  endtask

  task automatic test_store();
    exp_t e;
    data_i = 32'h55555555;
    sb.push_back('{1'b0, 2'd0, last_load});
    run_xfer(1'b1, 2'd2, 1'b0, 32'h200, 32'hDEADBEEF, 3);
    e = sb.pop_front();
    n_checks++; if (!obs_got || obs_is_err !== 1'b0) begin n_fail++; $display("FAIL store_word_resp got=%0b err=%0b want done", obs_got, obs_is_err); end
    n_checks++; if (obs_we !== 4 || obs_rd !== 0 || obs_cycle !== 5) begin n_fail++; $display("FAIL store_word_timing we %0d rd %0d done_cyc %0d want 4 0 5", obs_we, obs_rd, obs_cycle); end
    n_checks++; if (obs_addr !== 32'h200 || obs_data !== 32'hDEADBEEF || obs_unstable) begin n_fail++; $display("FAIL store_word_bus addr %h data %h unstable %0b", obs_addr, obs_data, obs_unstable); end
    n_checks++; if (obs_rdata !== e.rdata) begin n_fail++; $display("FAIL store_word_rdata_held got %h want %h", obs_rdata, e.rdata); end
    sb.push_back('{1'b0, 2'd0, last_load});
    run_xfer(1'b1, 2'd0, 1'b0, 32'h201, 32'hAABBCC11, 0);
    e = sb.pop_front();
    n_checks++; if (!obs_got || obs_is_err !== 1'b0 || obs_cycle !== 2) begin n_fail++; $display("FAIL store_byte_resp got=%0b err=%0b cyc %0d want done 2", obs_got, obs_is_err, obs_cycle); end
    n_checks++; if (obs_data !== 32'h00000011 || obs_sel !== 2'd0 || obs_we !== 1) begin n_fail++; $display("FAIL store_byte_bus data %h sel %0d we %0d want 00000011 0 1", obs_data, obs_sel, obs_we); end
    n_checks++; if (obs_rdata !== e.rdata) begin n_fail++; $display("FAIL store_byte_rdata_held got %h want %h", obs_rdata, e.rdata); end
  endtask

  task automatic test_errors();
    logic [1:0]  szs[4]   = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic [31:0] addrs[4] = '{32'h101, 32'h102, 32'h100, 32'h101};
    logic [1:0]  codes[4] = '{2'd1, 2'd1, 2'd2, 2'd2};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{1'b1, codes[i], 32'h0});
      run_xfer(1'b0, szs[i], 1'b0, addrs[i], 32'h0, 0);
      e = sb.pop_front();
      n_checks++; if (!obs_got || obs_is_err !== e.is_err || obs_code !== e.code) begin n_fail++; $display("FAIL err%0d_code got=%0b err=%0b code %0d want err code %0d", i, obs_got, obs_is_err, obs_code, e.code); end
      n_checks++; if (obs_cycle !== 1 || obs_rd !== 0 || obs_we !== 0 || obs_busy !== 1'b0) begin n_fail++; $display("FAIL err%0d_side cyc %0d rd %0d we %0d busy %0b want 1 0 0 0", i, obs_cycle, obs_rd, obs_we, obs_busy); end
    end
    @(negedge clk);
    n_checks++; if (err_o !== 1'b0 || err_code_o !== 2'd2) begin n_fail++; $display("FAIL err_pulse_hold err %0b code %0d want 0 2", err_o, err_code_o); end
  endtask

  task automatic test_timeout();
    exp_t e;
    data_i = 32'h0BADF00D;
    sb.push_back('{1'b1, 2'd3, 32'h0});
    run_xfer(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, -1);
    e = sb.pop_front();
    n_checks++; if (!obs_got || obs_is_err !== e.is_err || obs_code !== e.code) begin n_fail++; $display("FAIL timeout_code got=%0b err=%0b code %0d want err 3", obs_got, obs_is_err, obs_code); end
    n_checks++; if (obs_rd !== 8 || obs_cycle !== 9 || obs_busy_end !== 1'b0) begin n_fail++; $display("FAIL timeout_timing rd %0d cyc %0d busy %0b want 8 9 0", obs_rd, obs_cycle, obs_busy_end); end
    // ack arriving on the terminal-count edge must win
    sb.push_back('{1'b0, 2'd0, 32'h0BADF00D});
    run_xfer(1'b0, 2'd2, 1'b0, 32'h404, 32'h0, 7);
    e = sb.pop_front();
    n_checks++; if (!obs_got || obs_is_err !== e.is_err || obs_rdata !== e.rdata) begin n_fail++; $display("FAIL ack_at_tc got=%0b err=%0b rdata %h want done %h", obs_got, obs_is_err, obs_rdata, e.rdata); end
    n_checks++; if (obs_rd !== 8 || obs_cycle !== 9) begin n_fail++; $display("FAIL ack_at_tc_timing rd %0d cyc %0d want 8 9", obs_rd, obs_cycle); end
    data_i = 32'h000000A5;
    sb.push_back('{1'b0, 2'd0, 32'hFFFFFFA5});
    run_xfer(1'b0, 2'd0, 1'b1, 32'h405, 32'h0, 0);
    e = sb.pop_front();
    n_checks++; if (!obs_got || obs_is_err !== 1'b0 || obs_rdata !== e.rdata || obs_cycle !== 2) begin n_fail++; $display("FAIL after_timeout rdata %h cyc %0d want %h 2", obs_rdata, obs_cycle, e.rdata); end
    last_load = 32'hFFFFFFA5;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      data_i = 32'h1000 * (i + 1) + 32'h8000_0000;
      sb.push_back('{1'b0, 2'd0, data_i});
      run_xfer(1'b0, 2'd2, 1'b0, 32'h500 + 4 * i, 32'h0, 0);
      e = sb.pop_front();
      n_checks++; if (!obs_got || obs_rdata !== e.rdata || obs_cycle !== 2 || obs_rd !== 1) begin n_fail++; $display("FAIL b2b%0d rdata %h cyc %0d rd %0d want %h 2 1", i, obs_rdata, obs_cycle, obs_rd, e.rdata); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic saw_resp;
    saw_resp = 1'b0;
    data_i = 32'h13579BDF;
    @(negedge clk);
    req_i = 1'b1; we_req_i = 1'b0; size_i = 2'd1; signed_i = 1'b0; addr_req_i = 32'h104; ack_i = 1'b0;
    @(negedge clk);
    req_i = 1'b0;
    n_checks++; if (rd_o !== 1'b1 || busy_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_start rd %0b busy %0b want 1 1", rd_o, busy_o); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (rd_o !== 1'b0 || busy_o !== 1'b0 || we_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_drop rd %0b we %0b busy %0b want 0 0 0", rd_o, we_o, busy_o); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done_o || err_o) saw_resp = 1'b1;
    end
    n_checks++; if (saw_resp !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_resp got %0b want 0", saw_resp); end
    sb.push_back('{1'b0, 2'd0, 32'h13579BDF});
    run_xfer(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 0);
    e = sb.pop_front();
    n_checks++; if (!obs_got || obs_is_err !== 1'b0 || obs_rdata !== e.rdata || obs_cycle !== 2) begin n_fail++; $display("FAIL rst_mid_after rdata %h cyc %0d want %h 2", obs_rdata, obs_cycle, e.rdata); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_store();
    test_errors();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    n_checks++; if (obs_both_strobe !== 1'b0) begin n_fail++; $display("FAIL rd_we_overlap got %0b want 0", obs_both_strobe); end
    n_checks++; if (obs_both_resp !== 1'b0) begin n_fail++; $display("FAIL done_err_overlap got %0b want 0", obs_both_resp); end
    n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_master_lsu.md
Name: bus_master_lsu

Overview:
Bus initiator that turns CPU load/store requests into single transfers on the system data bus that all memory-mapped devices answer (ROM, RAM, peripherals). The bus carries right-justified data with a size select and a per-device acknowledge.
- Enforces alignment and applies a bounded wait for acknowledge.
- Sign- or zero-extends read data.
- Presents a busy/done/error handshake to the pipeline, which stalls on busy_o.

Parameters:
TIMEOUT, 255, max cycles to wait for ack_i before abandoning a transfer (1..65535)
TO_W, 16, width of timeout counter; must hold TIMEOUT

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_i  input  1  CPU request strobe; sampled only in IDLE
we_req_i  input  1  1 = store, 0 = load
size_i  input  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal
signed_i  input  1  loads only: 1 = sign-extend, 0 = zero-extend
addr_req_i  input  32  byte address
wdata_i  input  32  store data, right-justified
busy_o  output  1  high while a transfer is outstanding
done_o  output  1  one-cycle pulse: transfer completed
rdata_o  output  32  extended load data, valid when done_o is high, held until the next done_o
err_o  output  1  one-cycle pulse: misaligned, illegal size, or timeout
err_code_o  output  2  0 = none, 1 = misaligned, 2 = illegal size, 3 = timeout; valid with err_o, held until the next err_o
addr_o  output  32  bus address
data_o  output  32  bus write data, right-justified, upper bits zero-masked per size
sel_o  output  2  bus size select, same encoding as size_i
rd_o  output  1  bus read strobe
we_o  output  1  bus write strobe
data_i  input  32  bus read data, right-justified
ack_i  input  1  device acknowledge; may be combinational (tied high)

Behaviour:
- Reset values:
  - state = IDLE
  - addr_o, data_o, rdata_o = 0
  - sel_o, err_code_o = 0
  - rd_o, we_o, busy_o, done_o, err_o = 0
  - timeout counter = 0
  - rst asserted mid-transfer drops rd_o/we_o immediately; no done_o/err_o is generated for the killed transfer.
- States: IDLE, BUS, RESP.
- IDLE, when req_i = 1, checks in priority order:
  - size_i == 3 -> err_o pulse, code 2, no bus cycle; stay in IDLE.
  - size_i == 1 with addr[0] != 0, or size_i == 2 with addr[1:0] != 0 -> err_o pulse, code 1, no bus cycle.
  - Otherwise, in the same edge: latch addr_o, sel_o, data_o (byte: wdata[7:0] zero-extended; half: wdata[15:0]); assert rd_o (load) or we_o (store); clear counter; enter BUS.
- BUS:
  - addr_o, data_o, sel_o and the strobe are held stable.
  - On an edge where ack_i = 1:
    - Load: capture data_i masked to size, then extended per signed_i, into rdata_o.
    - Store: rdata_o unchanged.
    - Drop the strobe and enter RESP.
  - Otherwise increment the counter. If the counter reaches TIMEOUT-1 without ack: drop the strobe, err_o pulse, code 3, return to IDLE.
- RESP: done_o = 1 for exactly this cycle, then IDLE.
- Strobe rules: rd_o and we_o are never both high; at most one strobe per request.
- busy_o = (state != IDLE), registered. req_i is ignored while busy_o = 1; the CPU must hold req_i until it sees busy_o.
- A misalignment error costs 1 cycle and never raises busy_o.
- Latency with ack tied high: req_i at edge N -> strobe high during cycle N+1 -> done_o high in cycle N+2. Back-to-back requests are accepted every 3 cycles.
- Simultaneous ack_i and timeout terminal count: ack wins, and the transfer completes normally.
- done_o and err_o are never high in the same cycle.

Decomposition:
- Shared package:
  - size encodings SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2.
  - error codes ERR_NONE, ERR_MISALIGN, ERR_SIZE, ERR_TIMEOUT.
  - state encodings.
- Sub-module bus_load_extend: combinational mask plus sign/zero extension of data_i by size and signed flag. It is reusable by the instruction-fetch path.

Test Plan:
- Load byte, signed, addr 0x103, ack tied 1, data_i = 0x000000F0 -> sel_o = 0, rd_o high 1 cycle, done_o 2 cycles after req, rdata_o = 0xFFFFFFF0. Repeat unsigned -> rdata_o = 0x000000F0.
- Load half, signed, addr 0x102, data_i = 0x12348001 (upper garbage) -> rdata_o = 0xFFFF8001; unsigned -> 0x00008001.
- Store word addr 0x200, wdata 0xDEADBEEF; ack delayed 3 cycles -> we_o high 4 cycles with addr/data stable, rd_o never high, done_o one cycle after ack; store byte wdata 0xAABBCC11 -> data_o = 0x00000011.
- Misaligned: half at 0x101 and word at 0x102 -> err_o 1 cycle, err_code_o = 1, rd_o/we_o/busy_o never asserted; size 3 -> err_code_o = 2.
- Timeout with TIMEOUT = 8, ack_i held 0 -> rd_o high exactly 8 cycles, err_o with code 3, busy_o falls; the next request then completes normally.
- Reset asserted in BUS cycle 2 of a delayed-ack load -> rd_o, busy_o low immediately, no done_o/err_o; req_i after release is accepted cleanly.
